// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the FIFO burst read master: FSM state encoding.
package fifo_rd_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fifo_burst_reader.sv
// Read-side burst master: pops ilen words from a show-ahead FIFO and streams them out
// through a registered valid/ready stage, pulsing odone when the burst completes.
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int pBITS  = 8,
    parameter int pLEN_W = 4
) (
    input  logic              iclk,
    input  logic              ireset,
    input  logic              istart,
    input  logic [pLEN_W-1:0] ilen,
    output logic              ofifo_rd,
    input  logic              ififo_empty,
    input  logic [pBITS-1:0]  ififo_data,
    output logic [pBITS-1:0]  odata,
    output logic              ovalid,
    input  logic              iready,
    output logic              obusy,
    output logic              odone,
    output logic [pLEN_W-1:0] oremain
);

    localparam logic [pLEN_W-1:0] LEN_ZERO = {pLEN_W{1'b0}};
    localparam logic [pLEN_W-1:0] LEN_ONE  = {{(pLEN_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    state_t            state_nxt_s;
    logic              load_s;
    logic              accept_s;
    logic [pLEN_W-1:0] remain_r;
    logic [pBITS-1:0]  data_r;
    logic              valid_r;
    logic              busy_r;
    logic              done_r;

    // Pop qualifier: head word present, words left, and the output register free or draining.
    always_comb begin
        load_s   = (state_r == RUN) && !ififo_empty && (remain_r != LEN_ZERO)
                   && (!valid_r || iready);
        accept_s = valid_r && iready;
    end

    // Next-state logic for the burst FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (istart) begin
                    state_nxt_s = (ilen != LEN_ZERO) ? RUN : DONE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (load_s && (remain_r == LEN_ONE)) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DRAIN: begin
                if (accept_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register; busy/done are decoded from the next state so they are flop outputs.
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == RUN) || (state_nxt_s == DRAIN);
            done_r  <= (state_nxt_s == DONE);
        end
    end

    // Remaining-word counter: loaded on start, only decremented by a pop so it cannot wrap.
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            remain_r <= LEN_ZERO;
        end else if ((state_r == IDLE) && istart) begin
            remain_r <= ilen;
        end else if (load_s) begin
            remain_r <= remain_r - LEN_ONE;
        end else begin
            remain_r <= remain_r;
        end
    end

    // Output stage: a load may replace an accepted word in the same cycle.
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            data_r  <= {pBITS{1'b0}};
            valid_r <= 1'b0;
        end else if (load_s) begin
            data_r  <= ififo_data;
            valid_r <= 1'b1;
        end else if (accept_s) begin
            data_r  <= data_r;
            valid_r <= 1'b0;
        end else begin
            data_r  <= data_r;
            valid_r <= valid_r;
        end
    end

    assign ofifo_rd = load_s;
    assign odata    = data_r;
    assign ovalid   = valid_r;
    assign obusy    = busy_r;
    assign odone    = done_r;
    assign oremain  = remain_r;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed and randomized bench for fifo_burst_reader; a queue-based FIFO/stream model supplies expectations.
module tb_fifo_burst_reader;

    logic       iclk = 1'b0;
    logic       ireset;
    logic       istart;
    logic [3:0] ilen;
    logic       ofifo_rd;
    logic       ififo_empty;
    logic [7:0] ififo_data;
    logic [7:0] odata;
    logic       ovalid;
    logic       iready;
    logic       obusy;
    logic       odone;
    logic [3:0] oremain;

    fifo_burst_reader #(.pBITS(8), .pLEN_W(4)) dut (
        .iclk(iclk), .ireset(ireset), .istart(istart), .ilen(ilen),
        .ofifo_rd(ofifo_rd), .ififo_empty(ififo_empty), .ififo_data(ififo_data),
        .odata(odata), .ovalid(ovalid), .iready(iready),
        .obusy(obusy), .odone(odone), .oremain(oremain)
    );

    always #5 iclk = ~iclk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] fq[$];       // FIFO contents (show-ahead, depth 4)
    logic [7:0] pend[$];     // words popped but not yet accepted by the sink
    logic [7:0] acc_log[$];  // words accepted during the current burst
    int accepts, pops, dones, exp_rem, iters;
    bit in_burst;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: present FIFO head, check at negedge+1, model the posedge, re-check after it.
    task automatic cyc();
        logic       do_pop, hold;
        logic [7:0] popped, held;
        ififo_empty = (fq.size() == 0);
        ififo_data  = (fq.size() != 0) ? fq[0] : 8'h00;
        #1;
        chk("rd_while_empty", {31'd0, ofifo_rd & ififo_empty}, 32'd0);
        chk("rd_while_stalled", {31'd0, ofifo_rd & ovalid & ~iready}, 32'd0);
        chk("busy_and_done", {31'd0, obusy & odone}, 32'd0);
        if (in_burst && !odone) begin
            chk("busy_in_burst", {31'd0, obusy}, 32'd1);
            chk("remain", {28'd0, oremain}, exp_rem);
        end
        if (odone) begin
            dones++;
            in_burst = 1'b0;
            chk("remain_at_done", {28'd0, oremain}, 32'd0);
        end
        if (ovalid && iready) begin
            chk("accept_data", {24'd0, odata}, (pend.size() != 0) ? {24'd0, pend.pop_front()} : 32'hxxxx_xxxx);
            acc_log.push_back(odata);
            accepts++;
        end
        do_pop = ofifo_rd;
        popped = 8'h00;
        if (do_pop) begin
            popped = (fq.size() != 0) ? fq.pop_front() : 8'hxx;
            pend.push_back(popped);
            pops++;
            exp_rem--;
        end
        hold = ovalid & ~iready;
        held = odata;
        @(posedge iclk);
        @(negedge iclk);
        if (do_pop) begin
            chk("pop_to_valid", {31'd0, ovalid}, 32'd1);
            chk("pop_to_data", {24'd0, odata}, {24'd0, popped});
        end
        if (hold) begin
            chk("hold_valid", {31'd0, ovalid}, 32'd1);
            chk("hold_data", {24'd0, odata}, {24'd0, held});
        end
    endtask

    task automatic start_burst(input int len);
        accepts = 0; pops = 0; dones = 0; exp_rem = len;
        acc_log.delete();
        istart = 1'b1;
        ilen   = 4'(len);
        cyc();
        istart   = 1'b0;
        in_burst = (len != 0);
    endtask

    // Run to completion: mode 0 ready=1, mode 1 ready=1,0,0,..., mode 2 random ready.
    task automatic finish_burst(input int len, input int mode, input bit refill, input bit ign);
        iters = 0;
        for (int c = 0; c < 400 && dones == 0; c++) begin
            case (mode)
                0:       iready = 1'b1;
                1:       iready = (c % 3 == 0);
                default: iready = 1'($urandom_range(0, 1));
            endcase
            if (refill && fq.size() < 4 && $urandom_range(0, 1) == 1)
                fq.push_back(8'($urandom_range(0, 255)));
            istart = ign && (c == 2);
            ilen   = ign ? 4'(len + 5) : 4'(len);
            cyc();
            iters++;
        end
        istart = 1'b0;
        chk("done_seen", dones, 32'd1);
        chk("accept_count", accepts, len);
        chk("pop_count", pops, len);
        iready = 1'b1;
        cyc();
        chk("single_done", dones, 32'd1);
        chk("idle_after_done", {30'd0, obusy, ovalid}, 32'd0);
    endtask

    initial begin
        ireset = 1'b1; istart = 1'b0; ilen = 4'd0; iready = 1'b0;
        ififo_empty = 1'b1; ififo_data = 8'h00;
        accepts = 0; pops = 0; dones = 0; exp_rem = 0; in_burst = 1'b0; iters = 0;
        repeat (2) @(negedge iclk);
        #1;
        chk("rst_state", {odata, 4'd0, oremain, 5'd0, ovalid, obusy, odone}, 32'd0);
        @(negedge iclk);
        ireset = 1'b0;
        cyc();

        // Sink always ready: three words back-to-back.
        fq.push_back(8'hA1); fq.push_back(8'hB2); fq.push_back(8'hC3);
        iready = 1'b1;
        start_burst(3);
        finish_burst(3, 0, 1'b0, 1'b0);
        chk("t1_latency", iters, 32'd5);
        chk("t1_order", {8'd0, acc_log[0], acc_log[1], acc_log[2]}, 32'h00A1B2C3);
        chk("t1_fifo_empty", fq.size(), 32'd0);

        // Backpressure pattern.
        for (int i = 0; i < 4; i++) fq.push_back(8'($urandom_range(0, 255)));
        start_burst(4);
        finish_burst(4, 1, 1'b0, 1'b0);

        // Empty-FIFO stall, then data arrives.
        iready = 1'b1;
        start_burst(2);
        for (int i = 0; i < 5; i++) cyc();
        chk("t3_no_pop", pops, 32'd0);
        chk("t3_stall", {30'd0, obusy, ovalid}, 32'd2);
        fq.push_back(8'h55);
        cyc();
        fq.push_back(8'h66);
        finish_burst(2, 0, 1'b0, 1'b0);
        chk("t3_words", {16'd0, acc_log[0], acc_log[1]}, 32'h00005566);

        // Zero length: done one cycle after start, FIFO untouched.
        fq.push_back(8'h11); fq.push_back(8'h22);
        start_burst(0);
        cyc();
        chk("t4_done", dones, 32'd1);
        chk("t4_no_pop", pops, 32'd0);
        chk("t4_fifo", {fq.size(), fq[0], fq[1]}, {32'd2, 8'h11, 8'h22});
        cyc();
        chk("t4_single_done", dones, 32'd1);

        // Start ignored while busy.
        start_burst(3);
        finish_burst(3, 2, 1'b1, 1'b1);

        // Randomized bursts including the maximum length.
        for (int k = 0; k < 6; k++) begin
            int len;
            len = $urandom_range(1, 15);
            start_burst(len);
            finish_burst(len, 2, 1'b1, 1'b0);
        end
        start_burst(15);
        finish_burst(15, 2, 1'b1, 1'b0);

        // Asynchronous reset mid-burst, then a fresh burst.
        while (fq.size() != 0) void'(fq.pop_front());
        for (int i = 0; i < 4; i++) fq.push_back(8'(8'h30 + i));
        iready = 1'b1;
        start_burst(4);
        cyc();
        cyc();
        iready = 1'b0;
        chk("t5_pre", {31'd0, ovalid, 28'd0, oremain}, {32'd1, 32'd2});
        #2 ireset = 1'b1;
        #1;
        chk("t5_async_rst", {odata, 4'd0, oremain, 4'd0, ofifo_rd, ovalid, obusy, odone}, 32'd0);
        pend.delete();
        in_burst = 1'b0;
        @(negedge iclk);
        ireset = 1'b0;
        cyc();
        iready = 1'b1;
        start_burst(2);
        finish_burst(2, 0, 1'b0, 1'b0);
        chk("t5_fresh", {16'd0, acc_log[0], acc_log[1]}, 32'h00003233);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
